// File: rtl/urv_irq_timer_front_pkg.sv
// Shared definitions for the IRQ/timer front-end: register map and
// CTRL/IRQ_STAT bit positions.
package urv_irq_timer_front_pkg;

   typedef enum logic [1:0] {
      URV_IRQT_CTRL     = 2'd0,
      URV_IRQT_PERIOD   = 2'd1,
      URV_IRQT_COUNT    = 2'd2,
      URV_IRQT_IRQ_STAT = 2'd3
   } urv_irqt_reg_e;

   localparam int URV_IRQT_NUM_IRQ         = 8;
   localparam int URV_IRQT_CTRL_EN_BIT     = 0;
   localparam int URV_IRQT_CTRL_EDGE_LSB   = 8;
   localparam int URV_IRQT_STAT_LEVEL_LSB  = 0;
   localparam int URV_IRQT_STAT_STICKY_LSB = 8;

endpackage

// File: rtl/urv_irq_timer_front_if.sv
// Register port between the bus/CSR glue (master) and the front-end (slave).
interface urv_irq_timer_front_if;

   logic [1:0]  addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;

   modport master (output addr, output wdata, output we, input rdata);
   modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/urv_irq_sync.sv
// One IRQ line: multi-flop synchroniser, edge/level qualification and a
// write-1-clear sticky edge flag.
module urv_irq_sync #(
   parameter int g_sync_stages = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic irq_i,
   input  logic edge_mode_i,
   input  logic clr_i,
   output logic level_o,
   output logic irq_o,
   output logic sticky_o
);

   logic [g_sync_stages-1:0] sync_q;
   logic                     prev_q;
   logic                     rise;

   assign level_o = sync_q[g_sync_stages-1];
   assign rise    = level_o & ~prev_q;

   // prev_q tracks the synced level in both modes, so switching to edge
   // mode while the line is already high cannot fake a rising edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         prev_q   <= 1'b0;
         irq_o    <= 1'b0;
         sticky_o <= 1'b0;
      end else begin
         sync_q <= {sync_q[g_sync_stages-2:0], irq_i};
         prev_q <= level_o;
         irq_o  <= edge_mode_i ? rise : level_o;
         if (edge_mode_i && rise)
            sticky_o <= 1'b1;
         else if (clr_i)
            sticky_o <= 1'b0;
      end
   end

endmodule

// File: rtl/urv_irq_timer_front.sv
// Interrupt/timer front-end: 8 synchronised IRQ lines plus a prescaled
// periodic timer, controlled through a 4-word register port.
module urv_irq_timer_front
   import urv_irq_timer_front_pkg::*;
#(
   parameter int          g_sync_stages    = 2,
   parameter int          g_timer_div      = 1,
   parameter logic [31:0] g_default_period = 32'd0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            irq_i,
   urv_irq_timer_front_if.slave  bus,
   output logic [7:0]            exp_irq_o,
   output logic                  exp_tick_o
);

   localparam logic [31:0] DIV_LAST = 32'(g_timer_div - 1);

   logic        timer_en;
   logic [7:0]  edge_mode;
   logic [31:0] period;
   logic [31:0] count;
   logic [31:0] presc;
   logic [7:0]  sync_level;
   logic [7:0]  sticky;
   logic [7:0]  stat_clr;
   logic        wr_ctrl;
   logic        wr_period;
   logic        wr_count;
   logic        step;

   assign wr_ctrl   = bus.we && (bus.addr == URV_IRQT_CTRL);
   assign wr_period = bus.we && (bus.addr == URV_IRQT_PERIOD);
   assign wr_count  = bus.we && (bus.addr == URV_IRQT_COUNT);
   assign stat_clr  = (bus.we && (bus.addr == URV_IRQT_IRQ_STAT)) ?
                      bus.wdata[URV_IRQT_STAT_STICKY_LSB +: 8] : 8'h00;
   assign step      = timer_en && (presc == DIV_LAST);

   for (genvar n = 0; n < URV_IRQT_NUM_IRQ; n++) begin : g_irq
      urv_irq_sync #(
         .g_sync_stages (g_sync_stages)
      ) u_sync (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .irq_i       (irq_i[n]),
         .edge_mode_i (edge_mode[n]),
         .clr_i       (stat_clr[n]),
         .level_o     (sync_level[n]),
         .irq_o       (exp_irq_o[n]),
         .sticky_o    (sticky[n])
      );
   end

   // A software COUNT write takes priority over a timer step; PERIOD 0
   // freezes the counter so it never matches and never ticks.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_en   <= 1'b0;
         edge_mode  <= '0;
         period     <= g_default_period;
         count      <= '0;
         presc      <= '0;
         exp_tick_o <= 1'b0;
      end else begin
         exp_tick_o <= 1'b0;
         if (wr_ctrl) begin
            timer_en  <= bus.wdata[URV_IRQT_CTRL_EN_BIT];
            edge_mode <= bus.wdata[URV_IRQT_CTRL_EDGE_LSB +: 8];
         end
         if (wr_period)
            period <= bus.wdata;
         if (!timer_en || step)
            presc <= '0;
         else
            presc <= presc + 32'd1;
         if (wr_count) begin
            count <= bus.wdata;
         end else if (step && (period != 32'd0)) begin
            if (count == period) begin
               count      <= '0;
               exp_tick_o <= 1'b1;
            end else begin
               count <= count + 32'd1;
            end
         end
      end
   end

   always_comb begin
      bus.rdata = '0;
      case (urv_irqt_reg_e'(bus.addr))
         URV_IRQT_CTRL: begin
            bus.rdata[URV_IRQT_CTRL_EN_BIT]          = timer_en;
            bus.rdata[URV_IRQT_CTRL_EDGE_LSB +: 8]   = edge_mode;
         end
         URV_IRQT_PERIOD:   bus.rdata = period;
         URV_IRQT_COUNT:    bus.rdata = count;
         URV_IRQT_IRQ_STAT: begin
            bus.rdata[URV_IRQT_STAT_LEVEL_LSB +: 8]  = sync_level;
            bus.rdata[URV_IRQT_STAT_STICKY_LSB +: 8] = sticky;
         end
      endcase
   end

endmodule

// File: tb/tb_urv_irq_timer_front.sv
// Directed bench for urv_irq_timer_front: reset, edge/level IRQ lines,
// prescaled timer, write collisions and timer corner cases.
module tb_urv_irq_timer_front;
   import urv_irq_timer_front_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq;
   logic [7:0] exp_irq;
   logic       exp_tick;
   int         errors = 0;
   int         checks = 0;

   urv_irq_timer_front_if bus();

   urv_irq_timer_front #(
      .g_sync_stages    (2),
      .g_timer_div      (4),
      .g_default_period (32'd7)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .irq_i      (irq),
      .bus        (bus),
      .exp_irq_o  (exp_irq),
      .exp_tick_o (exp_tick)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; the write lands on the next rising edge and
   // the task returns on the falling edge after it.
   task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
      bus.addr  = addr;
      bus.wdata = data;
      bus.we    = 1'b1;
      @(negedge clk);
      bus.we    = 1'b0;
   endtask

   task automatic regRead(input logic [1:0] addr, output logic [31:0] data);
      bus.addr = addr;
      #1;
      data = bus.rdata;
   endtask

   initial begin
      logic [31:0] rd;
      int          pulses;
      int          first;
      int          second;

      rst       = 1'b1;
      irq       = 8'hFF;
      bus.addr  = 2'd0;
      bus.wdata = 32'd0;
      bus.we    = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_exp_irq", {24'h0, exp_irq}, 32'h0);
      checkOutput("rst_tick", {31'h0, exp_tick}, 32'h0);
      regRead(URV_IRQT_PERIOD, rd);
      checkOutput("rst_period", rd, 32'd7);
      regRead(URV_IRQT_COUNT, rd);
      checkOutput("rst_count", rd, 32'd0);
      regRead(URV_IRQT_CTRL, rd);
      checkOutput("rst_ctrl", rd, 32'd0);
      rst = 1'b0;
      irq = 8'h00;
      repeat (4) @(negedge clk);

      // Edge line 0: one pulse three cycles after the rise.
      applyStimulus(URV_IRQT_CTRL, 32'h0000_0100);
      irq[0] = 1'b1;
      pulses = 0;
      first  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (exp_irq[0]) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      checkOutput("edge_pulse_count", pulses, 32'd1);
      checkOutput("edge_latency", first, 32'd3);
      regRead(URV_IRQT_IRQ_STAT, rd);
      checkOutput("edge_stat_set", rd, 32'h0000_0101);
      applyStimulus(URV_IRQT_IRQ_STAT, 32'h0000_0100);
      regRead(URV_IRQT_IRQ_STAT, rd);
      checkOutput("edge_stat_w1c", rd, 32'h0000_0001);
      irq[0] = 1'b0;

      // Level line 3: output follows the synced input, three cycles late.
      applyStimulus(URV_IRQT_CTRL, 32'h0);
      repeat (4) @(negedge clk);
      irq[3] = 1'b1;
      pulses = 0;
      first  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (exp_irq[3]) begin
            pulses++;
            if (first == 0) first = i;
         end
         if (i == 10) irq[3] = 1'b0;
      end
      checkOutput("level_high_cycles", pulses, 32'd10);
      checkOutput("level_latency", first, 32'd3);

      // Switching a high level line to edge mode must not pulse.
      irq[2] = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("toggle_level_high", {31'h0, exp_irq[2]}, 32'd1);
      applyStimulus(URV_IRQT_CTRL, 32'h0000_0400);
      pulses = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (exp_irq[2]) pulses++;
      end
      checkOutput("toggle_no_pulse", pulses, 32'd0);
      irq[2] = 1'b0;

      // Timer div 4, period 5: tick every 24 cycles, COUNT 0..5.
      applyStimulus(URV_IRQT_PERIOD, 32'd5);
      applyStimulus(URV_IRQT_COUNT, 32'd0);
      applyStimulus(URV_IRQT_CTRL, 32'h1);
      bus.addr = URV_IRQT_COUNT;
      pulses = 0;
      first  = 0;
      second = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (exp_tick) begin
            pulses++;
            if (first == 0) first = i;
            else if (second == 0) second = i;
         end
         if ((i % 4 == 0) && (i <= 24))
            checkOutput("count_seq", bus.rdata, 32'((i / 4) % 6));
      end
      checkOutput("tick_first", first, 32'd24);
      checkOutput("tick_second", second, 32'd48);
      checkOutput("tick_count", pulses, 32'd2);

      // W1C of sticky[1] in the same cycle its edge arrives: set wins.
      applyStimulus(URV_IRQT_CTRL, 32'h0000_0200);
      repeat (3) @(negedge clk);
      irq[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      applyStimulus(URV_IRQT_IRQ_STAT, 32'h0000_0200);
      checkOutput("collide_pulse", {31'h0, exp_irq[1]}, 32'd1);
      regRead(URV_IRQT_IRQ_STAT, rd);
      checkOutput("collide_sticky", rd, 32'h0000_0202);
      irq[1] = 1'b0;

      // COUNT write on the cycle of the PERIOD match: no tick, COUNT=2.
      applyStimulus(URV_IRQT_COUNT, 32'd0);
      applyStimulus(URV_IRQT_CTRL, 32'h1);
      repeat (23) @(negedge clk);
      applyStimulus(URV_IRQT_COUNT, 32'd2);
      checkOutput("cwrite_no_tick", {31'h0, exp_tick}, 32'd0);
      regRead(URV_IRQT_COUNT, rd);
      checkOutput("cwrite_count", rd, 32'd2);
      @(negedge clk);
      checkOutput("cwrite_no_tick_late", {31'h0, exp_tick}, 32'd0);

      // PERIOD 0 keeps the timer silent and COUNT at 0.
      applyStimulus(URV_IRQT_CTRL, 32'h0);
      applyStimulus(URV_IRQT_PERIOD, 32'd0);
      applyStimulus(URV_IRQT_COUNT, 32'd0);
      applyStimulus(URV_IRQT_CTRL, 32'h1);
      pulses = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (exp_tick) pulses++;
      end
      checkOutput("p0_no_tick", pulses, 32'd0);
      regRead(URV_IRQT_COUNT, rd);
      checkOutput("p0_count", rd, 32'd0);

      // PERIOD below COUNT: counter runs past the match value.
      applyStimulus(URV_IRQT_CTRL, 32'h0);
      applyStimulus(URV_IRQT_COUNT, 32'd10);
      applyStimulus(URV_IRQT_PERIOD, 32'd3);
      applyStimulus(URV_IRQT_CTRL, 32'h1);
      pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (exp_tick) pulses++;
      end
      checkOutput("pbelow_no_tick", pulses, 32'd0);
      regRead(URV_IRQT_COUNT, rd);
      checkOutput("pbelow_count", rd, 32'd20);

      // Jump near the top: FFFFFFFE, FFFFFFFF, 0 (no tick), 1, 2, 3, tick.
      applyStimulus(URV_IRQT_CTRL, 32'h0);
      applyStimulus(URV_IRQT_COUNT, 32'hFFFF_FFFE);
      applyStimulus(URV_IRQT_CTRL, 32'h1);
      bus.addr = URV_IRQT_COUNT;
      pulses = 0;
      first  = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (exp_tick) begin
            pulses++;
            if (first == 0) first = i;
         end
         if (i == 4) checkOutput("wrap_count_max", bus.rdata, 32'hFFFF_FFFF);
         if (i == 8) begin
            checkOutput("wrap_count_zero", bus.rdata, 32'd0);
            checkOutput("wrap_no_tick", {31'h0, exp_tick}, 32'd0);
         end
      end
      checkOutput("wrap_tick_first", first, 32'd24);
      checkOutput("wrap_tick_count", pulses, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
